// File: rtl/pp_sched_pkg.sv
// Shared types and defaults for the ping-pong bank scheduler.
// Imported by the fill tracker and the scheduler top.
package pp_sched_pkg;

  localparam int DEF_FILL_WORDS = 8;
  localparam int DEF_PASS_LEN   = 4;
  localparam int DEF_NUM_PASSES = 2;
  localparam int DEF_RST_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    RUN,
    WAIT_ACC,
    WAIT_FIN,
    REL
  } sched_state_t;

  typedef logic bank_sel_t;

  // Counter width that stays at least one bit for degenerate parameter values.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pp_fill_tracker.sv
// Producer side of the ping-pong bridge: write address, bank steering,
// per-bank full flags, registered in_ready and sticky overflow.
module pp_fill_tracker
  import pp_sched_pkg::*;
#(
  parameter int FILL_WORDS = DEF_FILL_WORDS,
  parameter int ADDR_W     = $clog2(FILL_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              rel_en,
  input  bank_sel_t         rel_sel,
  output logic [1:0]        wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        full,
  output logic              in_ready,
  output logic              overflow_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FILL_WORDS - 1);

  bank_sel_t         wr_sel;
  bank_sel_t         wr_sel_n;
  logic [1:0]        full_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic              accept;
  logic              last_beat;

  assign accept    = in_valid & in_ready;
  assign last_beat = accept && (wr_addr == LAST_ADDR);
  assign wr_en     = accept ? (wr_sel ? 2'b10 : 2'b01) : 2'b00;

  // Release is applied before the fill so a bank freed this cycle is
  // already visible when in_ready is recomputed for the new write bank.
  always_comb begin
    full_n    = full;
    wr_sel_n  = wr_sel;
    wr_addr_n = wr_addr;
    if (rel_en) begin
      full_n[rel_sel] = 1'b0;
    end
    if (accept) begin
      wr_addr_n = last_beat ? '0 : wr_addr + ADDR_W'(1);
    end
    if (last_beat) begin
      full_n[wr_sel] = 1'b1;
      wr_sel_n       = ~wr_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel       <= 1'b0;
      wr_addr      <= '0;
      full         <= 2'b00;
      in_ready     <= 1'b1;
      overflow_err <= 1'b0;
    end else begin
      wr_sel       <= wr_sel_n;
      wr_addr      <= wr_addr_n;
      full         <= full_n;
      in_ready     <= ~full_n[wr_sel_n];
      overflow_err <= overflow_err | (in_valid & ~in_ready);
    end
  end

endmodule

// File: rtl/pp_bank_scheduler.sv
// Two-bank ping-pong controller between the projection producer and the
// matmul consumer; the consumer sequencing FSM lives here.
module pp_bank_scheduler
  import pp_sched_pkg::*;
#(
  parameter int FILL_WORDS = DEF_FILL_WORDS,
  parameter int PASS_LEN   = DEF_PASS_LEN,
  parameter int NUM_PASSES = DEF_NUM_PASSES,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int ADDR_W     = $clog2(FILL_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [1:0]        wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_sel,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              acc_done_wrap,
  input  logic              systolic_finish_wrap,
  output logic              internal_rst_n_ctrl,
  output logic              internal_reset_acc_ctrl,
  output logic              enable_matmul,
  output logic              out_valid,
  output logic              overflow_err,
  output logic              busy
);

  localparam int IDX_W  = cnt_width(PASS_LEN);
  localparam int PASS_W = cnt_width(NUM_PASSES);
  localparam int RCNT_W = cnt_width(RST_CYCLES);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PASS_LEN - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASSES - 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RST_CYCLES - 1);

  sched_state_t      state;
  sched_state_t      state_n;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_n;
  logic [PASS_W-1:0] pass_q;
  logic [PASS_W-1:0] pass_n;
  logic [RCNT_W-1:0] rcnt_q;
  logic [RCNT_W-1:0] rcnt_n;
  logic [ADDR_W-1:0] rd_addr_n;
  logic              rd_sel_n;
  logic [1:0]        full;
  logic              rel_en;

  assign rel_en = (state == REL);

  pp_fill_tracker #(
    .FILL_WORDS (FILL_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_fill (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .rel_en       (rel_en),
    .rel_sel      (rd_sel),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .full         (full),
    .in_ready     (in_ready),
    .overflow_err (overflow_err)
  );

  always_comb begin
    state_n   = state;
    idx_n     = idx_q;
    pass_n    = pass_q;
    rcnt_n    = rcnt_q;
    rd_addr_n = rd_addr;
    rd_sel_n  = rd_sel;
    case (state)
      IDLE: begin
        if (full[rd_sel]) begin
          state_n = RST;
          rcnt_n  = '0;
        end
      end
      RST: begin
        if (rcnt_q == RCNT_LAST) begin
          state_n = RUN;
          pass_n  = '0;
          idx_n   = '0;
        end else begin
          rcnt_n = rcnt_q + RCNT_W'(1);
        end
      end
      RUN: begin
        if (idx_q == IDX_LAST) begin
          state_n = WAIT_ACC;
        end else begin
          idx_n = idx_q + IDX_W'(1);
        end
      end
      WAIT_ACC: begin
        if (acc_done_wrap) begin
          if (pass_q != PASS_LAST) begin
            pass_n  = pass_q + PASS_W'(1);
            idx_n   = '0;
            state_n = RUN;
          end else begin
            state_n = WAIT_FIN;
          end
        end
      end
      WAIT_FIN: begin
        if (systolic_finish_wrap) begin
          state_n = REL;
        end
      end
      REL: begin
        state_n  = IDLE;
        rd_sel_n = ~rd_sel;
      end
      default: state_n = IDLE;
    endcase
    // Read address only advances while streaming; the wait states hold it.
    if (state_n == RUN) begin
      rd_addr_n = ADDR_W'(pass_n * PASS_LEN) + ADDR_W'(idx_n);
    end
  end

  // Outputs are registered from next-state values so they line up with the
  // state the FSM occupies during the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                   <= IDLE;
      idx_q                   <= '0;
      pass_q                  <= '0;
      rcnt_q                  <= '0;
      rd_sel                  <= 1'b0;
      rd_addr                 <= '0;
      internal_rst_n_ctrl     <= 1'b1;
      internal_reset_acc_ctrl <= 1'b0;
      enable_matmul           <= 1'b0;
      out_valid               <= 1'b0;
      busy                    <= 1'b0;
    end else begin
      state                   <= state_n;
      idx_q                   <= idx_n;
      pass_q                  <= pass_n;
      rcnt_q                  <= rcnt_n;
      rd_sel                  <= rd_sel_n;
      rd_addr                 <= rd_addr_n;
      internal_rst_n_ctrl     <= (state_n != RST);
      internal_reset_acc_ctrl <= (state_n == RUN) && (idx_n == '0);
      enable_matmul           <= (state_n == RUN) || (state_n == WAIT_ACC) || (state_n == WAIT_FIN);
      out_valid               <= (state_n == REL);
      busy                    <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_pp_bank_scheduler.sv
// Directed self-checking bench for pp_bank_scheduler with the default
// geometry (8 words per bank, 2 passes of 4, 2 reset cycles).
module tb_pp_bank_scheduler;

  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              acc_done_wrap = 1'b0;
  logic              systolic_finish_wrap = 1'b0;
  logic              in_ready;
  logic [1:0]        wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_sel;
  logic [ADDR_W-1:0] rd_addr;
  logic              internal_rst_n_ctrl;
  logic              internal_reset_acc_ctrl;
  logic              enable_matmul;
  logic              out_valid;
  logic              overflow_err;
  logic              busy;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] obs;
  localparam logic [15:0] RESET_VEC = {1'b1, 2'b00, 3'd0, 1'b0, 3'd0, 1'b1, 5'b00000};

  assign obs = {in_ready, wr_en, wr_addr, rd_sel, rd_addr, internal_rst_n_ctrl,
                internal_reset_acc_ctrl, enable_matmul, out_valid, overflow_err, busy};

  always #5 clk = ~clk;

  pp_bank_scheduler #(
    .FILL_WORDS (8),
    .PASS_LEN   (4),
    .NUM_PASSES (2),
    .RST_CYCLES (2),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .in_valid                (in_valid),
    .in_ready                (in_ready),
    .wr_en                   (wr_en),
    .wr_addr                 (wr_addr),
    .rd_sel                  (rd_sel),
    .rd_addr                 (rd_addr),
    .acc_done_wrap           (acc_done_wrap),
    .systolic_finish_wrap    (systolic_finish_wrap),
    .internal_rst_n_ctrl     (internal_rst_n_ctrl),
    .internal_reset_acc_ctrl (internal_reset_acc_ctrl),
    .enable_matmul           (enable_matmul),
    .out_valid               (out_valid),
    .overflow_err            (overflow_err),
    .busy                    (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    acc_done_wrap = 1'b0;
    systolic_finish_wrap = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push_beats(input int n);
    in_valid = 1'b1;
    repeat (n) step();
    in_valid = 1'b0;
  endtask

  // Holding both completion inputs high walks the consumer to REL, since each
  // is ignored outside its own wait state. Returns during the REL cycle.
  task automatic drain_bank(input string name);
    int waited = 0;
    acc_done_wrap = 1'b1;
    systolic_finish_wrap = 1'b1;
    while (out_valid !== 1'b1 && waited < 60) begin
      step();
      waited++;
    end
    acc_done_wrap = 1'b0;
    systolic_finish_wrap = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL %s_timeout: out_valid=%b want 1 after %0d cycles", name, out_valid, waited); end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (obs !== RESET_VEC) begin tests_failed++; $display("[TB] FAIL reset_outputs: got %b want %b", obs, RESET_VEC); end
    repeat (3) step();
    tests_run++;
    if (busy !== 1'b0 || internal_rst_n_ctrl !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_idle: busy=%b rst_n=%b want 0 1", busy, internal_rst_n_ctrl); end
  endtask

  task automatic test_single_bank();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      #1;
      tests_run++;
      if ({wr_en, wr_addr} !== {2'b01, 3'(i)}) begin tests_failed++; $display("[TB] FAIL sb_write%0d: wr_en=%b wr_addr=%0d want 01 %0d", i, wr_en, wr_addr, i); end
      step();
    end
    in_valid = 1'b0;
    tests_run++;
    if ({busy, internal_rst_n_ctrl, in_ready, wr_addr} !== {1'b0, 1'b1, 1'b1, 3'd0}) begin tests_failed++; $display("[TB] FAIL sb_after_fill: busy rst_n in_ready wr_addr=%b want 0110", {busy, internal_rst_n_ctrl, in_ready, wr_addr}); end
    for (int c = 0; c < 2; c++) begin
      step();
      tests_run++;
      if ({internal_rst_n_ctrl, enable_matmul, busy} !== 3'b001) begin tests_failed++; $display("[TB] FAIL sb_rst%0d: rst_n en busy=%b want 001", c, {internal_rst_n_ctrl, enable_matmul, busy}); end
    end
    step();
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 4; k++) begin
        tests_run++;
        if ({enable_matmul, internal_rst_n_ctrl, internal_reset_acc_ctrl, rd_addr} !== {1'b1, 1'b1, (k == 0), 3'(p * 4 + k)}) begin
          tests_failed++; $display("[TB] FAIL sb_run_p%0d_k%0d: en rst_n acc rd_addr=%b want 11%0d %0d", p, k, {enable_matmul, internal_rst_n_ctrl, internal_reset_acc_ctrl, rd_addr}, (k == 0), p * 4 + k);
        end
        step();
      end
      tests_run++;
      if ({enable_matmul, internal_reset_acc_ctrl, rd_addr} !== {1'b1, 1'b0, 3'(p * 4 + 3)}) begin tests_failed++; $display("[TB] FAIL sb_wait_acc%0d: en acc rd_addr=%b want 10 %0d", p, {enable_matmul, internal_reset_acc_ctrl, rd_addr}, p * 4 + 3); end
      acc_done_wrap = 1'b1;
      step();
      acc_done_wrap = 1'b0;
    end
    tests_run++;
    if ({enable_matmul, out_valid, busy} !== 3'b101) begin tests_failed++; $display("[TB] FAIL sb_wait_fin: en out_valid busy=%b want 101", {enable_matmul, out_valid, busy}); end
    systolic_finish_wrap = 1'b1;
    step();
    systolic_finish_wrap = 1'b0;
    tests_run++;
    if ({out_valid, rd_sel, enable_matmul} !== 3'b100) begin tests_failed++; $display("[TB] FAIL sb_rel: out_valid rd_sel en=%b want 100", {out_valid, rd_sel, enable_matmul}); end
    step();
    tests_run++;
    if ({out_valid, rd_sel, busy} !== 3'b010) begin tests_failed++; $display("[TB] FAIL sb_after_rel: out_valid rd_sel busy=%b want 010", {out_valid, rd_sel, busy}); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      #1;
      tests_run++;
      if ({wr_en, wr_addr} !== {(i < 8) ? 2'b01 : 2'b10, 3'(i % 8)}) begin tests_failed++; $display("[TB] FAIL bp_write%0d: wr_en=%b wr_addr=%0d want %b %0d", i, wr_en, wr_addr, (i < 8) ? 2'b01 : 2'b10, i % 8); end
      step();
    end
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_in_ready_low: got %b want 0", in_ready); end
    #1;
    tests_run++;
    if (wr_en !== 2'b00) begin tests_failed++; $display("[TB] FAIL bp_drop_wr_en: got %b want 00", wr_en); end
    step();
    in_valid = 1'b0;
    tests_run++;
    if ({overflow_err, in_ready, wr_addr} !== {1'b1, 1'b0, 3'd0}) begin tests_failed++; $display("[TB] FAIL bp_after_drop: overflow in_ready wr_addr=%b want 10000", {overflow_err, in_ready, wr_addr}); end
  endtask

  task automatic test_release_recovery();
    drain_bank("rr");
    tests_run++;
    if ({in_ready, rd_sel} !== 2'b00) begin tests_failed++; $display("[TB] FAIL rr_rel_cycle: in_ready rd_sel=%b want 00", {in_ready, rd_sel}); end
    step();
    tests_run++;
    if ({in_ready, rd_sel, busy, overflow_err} !== 4'b1101) begin tests_failed++; $display("[TB] FAIL rr_after_rel: in_ready rd_sel busy overflow=%b want 1101", {in_ready, rd_sel, busy, overflow_err}); end
    step();
    tests_run++;
    if ({internal_rst_n_ctrl, busy} !== 2'b01) begin tests_failed++; $display("[TB] FAIL rr_bank1_start: rst_n busy=%b want 01", {internal_rst_n_ctrl, busy}); end
  endtask

  task automatic test_spurious_pulses();
    do_reset();
    push_beats(8);
    repeat (3) step();
    acc_done_wrap = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if ({enable_matmul, rd_addr} !== {1'b1, 3'(k)}) begin tests_failed++; $display("[TB] FAIL sp_run%0d: en rd_addr=%b want 1 %0d", k, {enable_matmul, rd_addr}, k); end
      step();
    end
    acc_done_wrap = 1'b0;
    systolic_finish_wrap = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tests_run++;
      if ({enable_matmul, internal_reset_acc_ctrl, rd_addr} !== {1'b1, 1'b0, 3'd3}) begin tests_failed++; $display("[TB] FAIL sp_hold%0d: en acc rd_addr=%b want 10 3", c, {enable_matmul, internal_reset_acc_ctrl, rd_addr}); end
      step();
    end
    systolic_finish_wrap = 1'b0;
    acc_done_wrap = 1'b1;
    step();
    acc_done_wrap = 1'b0;
    tests_run++;
    if ({internal_reset_acc_ctrl, rd_addr} !== {1'b1, 3'd4}) begin tests_failed++; $display("[TB] FAIL sp_pass1: acc rd_addr=%b want 1 4", {internal_reset_acc_ctrl, rd_addr}); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    push_beats(17);
    drain_bank("mr");
    step();
    push_beats(3);
    step();
    step();
    tests_run++;
    if ({enable_matmul, rd_addr, overflow_err, wr_addr} !== {1'b1, 3'd2, 1'b1, 3'd3}) begin tests_failed++; $display("[TB] FAIL mr_pre: en rd_addr ovf wr_addr=%b want 1 010 1 011", {enable_matmul, rd_addr, overflow_err, wr_addr}); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++;
    if (obs !== RESET_VEC) begin tests_failed++; $display("[TB] FAIL mr_outputs: got %b want %b", obs, RESET_VEC); end
    repeat (4) step();
    tests_run++;
    if ({busy, in_ready} !== 2'b01) begin tests_failed++; $display("[TB] FAIL mr_banks_empty: busy in_ready=%b want 01", {busy, in_ready}); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    push_beats(16);
    drain_bank("sim0");
    step();
    tests_run++;
    if ({in_ready, rd_sel} !== 2'b11) begin tests_failed++; $display("[TB] FAIL sim_bank0_free: in_ready rd_sel=%b want 11", {in_ready, rd_sel}); end
    push_beats(7);
    tests_run++;
    if (wr_addr !== 3'd7) begin tests_failed++; $display("[TB] FAIL sim_partial: wr_addr=%0d want 7", wr_addr); end
    drain_bank("sim1");
    in_valid = 1'b1;
    #1;
    tests_run++;
    if ({wr_en, rd_sel} !== 3'b011) begin tests_failed++; $display("[TB] FAIL sim_same_cycle: wr_en rd_sel=%b want 011", {wr_en, rd_sel}); end
    step();
    in_valid = 1'b0;
    tests_run++;
    if ({in_ready, rd_sel, wr_addr, out_valid, busy} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin tests_failed++; $display("[TB] FAIL sim_after: in_ready rd_sel wr_addr out_valid busy=%b want 1000000", {in_ready, rd_sel, wr_addr, out_valid, busy}); end
    step();
    tests_run++;
    if ({internal_rst_n_ctrl, busy} !== 2'b01) begin tests_failed++; $display("[TB] FAIL sim_bank0_start: rst_n busy=%b want 01", {internal_rst_n_ctrl, busy}); end
    drain_bank("sim2");
    step();
    repeat (3) step();
    tests_run++;
    if ({rd_sel, busy} !== 2'b10) begin tests_failed++; $display("[TB] FAIL sim_bank1_cleared: rd_sel busy=%b want 10", {rd_sel, busy}); end
  endtask

  initial begin
    test_reset();
    test_single_bank();
    test_back_pressure();
    test_release_recovery();
    test_spurious_pulses();
    test_reset_mid_run();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pp_bank_scheduler.md
Name: pp_bank_scheduler

Overview:
Controller for the two-bank ping-pong bridge between linear projection (producer) and multi_matmul_wrapper (consumer).
- Producer side: steers producer writes into the free bank, tracks fill state, back-pressures when both banks are full.
- Consumer side: sequences the matmul over a full bank (reset, enable, per-pass accumulator reset, completion wait), then releases the bank.

Parameters:
- FILL_WORDS, 8: in_valid beats that fill one bank.
- PASS_LEN, 4: read beats per accumulation pass.
- NUM_PASSES, 2: passes per bank; PASS_LEN*NUM_PASSES must equal FILL_WORDS.
- RST_CYCLES, 2: cycles internal_rst_n_ctrl is held low before each bank run.
- ADDR_W, $clog2(FILL_WORDS): bank address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  producer data beat.
- in_ready  out  1  write bank available (registered).
- wr_en  out  2  one-hot bank write enable (in_valid & in_ready), combinational.
- wr_addr  out  ADDR_W  write address within bank.
- rd_sel  out  1  bank being read.
- rd_addr  out  ADDR_W  read address within bank.
- acc_done_wrap  in  1  matmul accumulation pass complete (pulse).
- systolic_finish_wrap  in  1  matmul array drained (pulse).
- internal_rst_n_ctrl  out  1  active-low matmul reset.
- internal_reset_acc_ctrl  out  1  accumulator clear pulse.
- enable_matmul  out  1  matmul enable / read strobe.
- out_valid  out  1  one-cycle pulse: bank result complete.
- overflow_err  out  1  sticky: in_valid while !in_ready.
- busy  out  1  consumer FSM not IDLE.

Behaviour:
- Reset values: in_ready=1, wr_en=0, wr_addr=0, rd_sel=0, rd_addr=0, internal_rst_n_ctrl=1, internal_reset_acc_ctrl=0, enable_matmul=0, out_valid=0, overflow_err=0, busy=0. Internal state: wr_sel=0, full[1:0]=0, FSM=IDLE. Reset mid-operation discards all bank state.
- Write side: an accepted beat increments wr_addr. On the beat with wr_addr==FILL_WORDS-1:
  - set full[wr_sel], wrap wr_addr to 0, toggle wr_sel.
  - in_ready(next) = !full[new wr_sel], evaluated after the same-cycle release.
- A beat with in_valid & !in_ready is dropped (no write, no address change) and sets overflow_err until rst.
- Consumer FSM:
  - IDLE: if full[rd_sel], go to RST. Else stay.
  - RST: internal_rst_n_ctrl=0 for exactly RST_CYCLES cycles, then go to RUN with pass=0, idx=0.
  - RUN: enable_matmul=1 every cycle. rd_addr=pass*PASS_LEN+idx. internal_reset_acc_ctrl=1 on idx==0 only. After idx==PASS_LEN-1, go to WAIT_ACC.
  - WAIT_ACC: enable_matmul=1 and rd_addr held. On acc_done_wrap: if pass<NUM_PASSES-1, do pass++, idx=0, go to RUN; else go to WAIT_FIN.
  - WAIT_FIN: enable_matmul=1. On systolic_finish_wrap go to REL.
  - REL (one cycle): clear full[rd_sel], toggle rd_sel, out_valid=1, go to IDLE.
- Latency:
  - Last fill beat to first enable_matmul: 1 (IDLE) + RST_CYCLES cycles, when the FSM is already in IDLE.
  - Release to in_ready high: 1 cycle.
- Simultaneous events:
  - Fill of bank A and release of bank B in the same cycle: both take effect.
  - A fill completing while the consumer runs the other bank is queued. IDLE starts it in the cycle after REL.
- acc_done_wrap or systolic_finish_wrap outside their wait states are ignored.
- All outputs except wr_en are registered.

Decomposition:
- Shared package pp_sched_pkg holds:
  - typedef enum sched_state_t {IDLE, RST, RUN, WAIT_ACC, WAIT_FIN, REL};
  - localparams for default FILL_WORDS, PASS_LEN, NUM_PASSES;
  - bank_sel_t typedef.
- Natural sub-module: pp_fill_tracker, covering write address, wr_sel, full[] flags and in_ready/overflow.
- The FSM stays in the top.

Test Plan (FILL_WORDS=8, PASS_LEN=4, NUM_PASSES=2, RST_CYCLES=2):
1. Single bank:
   - Stimulus: 8 consecutive in_valid beats.
   - Required: wr_en=01 with wr_addr 0..7; full[0] set; internal_rst_n_ctrl low for 2 cycles; enable_matmul high with rd_addr 0..3 and reset_acc at rd_addr 0.
   - Then: acc_done_wrap gives rd_addr 4..7 with reset_acc at rd_addr 4; systolic_finish_wrap gives out_valid pulse and rd_sel=1.
2. Back-pressure:
   - Stimulus: 16 beats, then a 17th while the consumer has not finished bank 0.
   - Required: in_ready=0 after beat 16; beat 17 dropped; overflow_err=1; wr_addr stays 0.
3. Release recovery: continuing scenario 2, complete bank 0 -> in_ready=1 one cycle after out_valid; bank 1 run starts in the cycle after REL.
4. Spurious pulses: acc_done_wrap asserted during RUN, systolic_finish_wrap during WAIT_ACC -> ignored, pass count unchanged.
5. Reset mid-RUN: rst asserted at rd_addr=2 -> next cycle all outputs at reset values, full=00, overflow_err=0.
6. Simultaneous events: last fill beat of bank 0 in the same cycle as REL of bank 1 -> full=01 afterwards, in_ready=1, and a new run starts on bank 0.
